// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  // An all-zero instruction word is what a flushed stage register captures.
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic md_busy;
    logic md_kill;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF       = 9'b0000_000_00;
  localparam ctrl_t CTRL_RUN       = 9'b1111_000_00;
  localparam ctrl_t CTRL_LOAD_USE  = 9'b0011_010_00;
  localparam ctrl_t CTRL_FLUSH_ALL = 9'b1111_111_00;
  localparam ctrl_t CTRL_MD_STALL  = 9'b0001_001_10;
  localparam ctrl_t CTRL_MD_KILL   = 9'b1111_111_01;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  output logic                  hit
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hit = ex_mem_read && ex_reg_write && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, MUL/DIV wait and branch squash.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_md_op,
  input  logic                  mem_branch_taken,
  output logic                  pc_load,
  output logic                  if_id_load,
  output logic                  id_ex_load,
  output logic                  ex_mem_load,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  md_busy,
  output logic                  md_kill,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int              MDC_W     = $clog2(MD_LATENCY) + 1;
  localparam bit              MD_STALLS = (MD_LATENCY > 1);
  localparam logic [MDC_W-1:0] MD_RELOAD = MDC_W'((MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0);

  state_e           state;
  state_e           state_nxt;
  logic [MDC_W-1:0] md_cnt;
  logic [MDC_W-1:0] md_cnt_nxt;
  logic             lu_hit;
  ctrl_t            ctrl;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lud (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .hit          (lu_hit)
  );

  // Output decode and next-state selection
  always_comb begin
    ctrl       = CTRL_RUN;
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (!rst) begin
      ctrl       = CTRL_OFF;
      state_nxt  = RUN;
      md_cnt_nxt = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_branch_taken) begin
            ctrl = CTRL_FLUSH_ALL;
          end else if (ex_md_op && MD_STALLS) begin
            ctrl       = CTRL_MD_STALL;
            state_nxt  = MD_WAIT;
            md_cnt_nxt = MD_RELOAD;
          end else if (lu_hit) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
        MD_WAIT: begin
          // The MUL/DIV op is younger than a branch resolving in MEM, so it dies with it.
          if (mem_branch_taken) begin
            ctrl       = CTRL_MD_KILL;
            state_nxt  = RUN;
            md_cnt_nxt = '0;
          end else if (md_cnt != '0) begin
            ctrl       = CTRL_MD_STALL;
            md_cnt_nxt = md_cnt - 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt  = RUN;
          md_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign pc_load      = ctrl.pc_load;
  assign if_id_load   = ctrl.if_id_load;
  assign id_ex_load   = ctrl.id_ex_load;
  assign ex_mem_load  = ctrl.ex_mem_load;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign md_busy      = ctrl.md_busy;
  assign md_kill      = ctrl.md_kill;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (!ctrl.pc_load && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       md;
    logic       br;
    logic [8:0] exp;
  } vec_t;

  // {pc_load, if_id_load, id_ex_load, ex_mem_load, if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_kill}
  localparam logic [8:0] E_OFF   = 9'b0000_000_00;
  localparam logic [8:0] E_RUN   = 9'b1111_000_00;
  localparam logic [8:0] E_LU    = 9'b0011_010_00;
  localparam logic [8:0] E_FLUSH = 9'b1111_111_00;
  localparam logic [8:0] E_MDS   = 9'b0001_001_10;
  localparam logic [8:0] E_KILL  = 9'b1111_111_01;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read, ex_md_op, mem_branch_taken;
  logic        pc_load, if_id_load, id_ex_load, ex_mem_load;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_kill;
  logic [15:0] stall_cycles;
  logic [8:0]  outs;

  int n_cmp;
  int n_bad;
  int exp_stalls;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (5),
    .MD_LATENCY (4),
    .CNT_W      (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_rd            (ex_rd),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_md_op         (ex_md_op),
    .mem_branch_taken (mem_branch_taken),
    .pc_load          (pc_load),
    .if_id_load       (if_id_load),
    .id_ex_load       (id_ex_load),
    .ex_mem_load      (ex_mem_load),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .md_busy          (md_busy),
    .md_kill          (md_kill),
    .stall_cycles     (stall_cycles)
  );

  assign outs = {pc_load, if_id_load, id_ex_load, ex_mem_load,
                 if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_kill};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic md, input logic br,
                               input logic [8:0] exp);
    vec_t v;
    v.name = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.rw = rw; v.mr = mr; v.md = md; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_reg_write = v.rw; ex_mem_read = v.mr;
    ex_md_op = v.md; mem_branch_taken = v.br;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input vec_t v);
    @(posedge clk);
    #1;
    apply(v);
    #3;
    chk(v.name, {23'b0, outs}, {23'b0, v.exp});
    if (!v.exp[8]) exp_stalls++;
  endtask

  vec_t tbl[11];
  vec_t idle, lu, md1, md0br;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_stalls = 0;

    idle  = mkv("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
    lu    = mkv("lu",   5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E_LU);
    md1   = mkv("md",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MDS);
    md0br = mkv("kill", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_KILL);

    tbl[0]  = mkv("t_idle",       5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
    tbl[1]  = mkv("t_lu_rs2",     5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E_LU);
    tbl[2]  = mkv("t_lu_rd0",     5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_RUN);
    tbl[3]  = mkv("t_lu_rs1",     5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, E_LU);
    tbl[4]  = mkv("t_rs1_unused", 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, E_RUN);
    tbl[5]  = mkv("t_no_rw",      5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, E_RUN);
    tbl[6]  = mkv("t_alu_src",    5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN);
    tbl[7]  = mkv("t_branch",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_FLUSH);
    tbl[8]  = mkv("t_br_md_lu",   5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, E_FLUSH);
    tbl[9]  = mkv("t_after_br",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
    tbl[10] = mkv("t_rs2_differ", 5'd0, 5'd6, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E_RUN);

    // Reset held 3 cycles with busy inputs
    rst = 1'b0;
    apply(md0br);
    repeat (3) @(posedge clk);
    #4;
    chk("rst_outs", {23'b0, outs}, {23'b0, E_OFF});
    chk("rst_cnt", {16'b0, stall_cycles}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(idle);
    #3;
    chk("rel_idle", {23'b0, outs}, {23'b0, E_RUN});

    for (int i = 0; i < 11; i++) tick(tbl[i]);
    tick(idle);
    chk("tbl_stalls", {16'b0, stall_cycles}, exp_stalls);

    // MUL/DIV: three stall cycles, release, immediate re-entry
    tick(md1);
    tick(md1);
    tick(md1);
    tick(mkv("md_release", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RUN));
    chk("md_stalls", {16'b0, stall_cycles}, exp_stalls);
    tick(mkv("md_b2b", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MDS));
    tick(md1);
    tick(md1);
    tick(mkv("md_rel2", 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E_RUN));
    tick(idle);
    chk("md_b2b_stalls", {16'b0, stall_cycles}, exp_stalls);

    // Branch resolving during MD_WAIT kills the op
    tick(md1);
    tick(md0br);
    tick(mkv("post_kill", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN));

    // Counter saturation under a persistent load-use hazard
    @(posedge clk);
    #1;
    apply(lu);
    repeat (65540) @(posedge clk);
    #4;
    chk("sat_cnt", {16'b0, stall_cycles}, 32'h0000_FFFF);
    chk("sat_outs", {23'b0, outs}, {23'b0, E_LU});

    // Asynchronous reset in the middle of MD_WAIT
    @(posedge clk);
    #1;
    apply(md1);
    @(posedge clk);
    #2;
    chk("mdw_busy", {31'b0, md_busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mdrst_outs", {23'b0, outs}, {23'b0, E_OFF});
    chk("mdrst_cnt", {16'b0, stall_cycles}, 32'd0);
    @(posedge clk);
    #1;
    chk("mdrst_kill", {31'b0, md_kill}, 32'd0);
    rst = 1'b1;
    apply(idle);
    #3;
    chk("mdrst_run", {23'b0, outs}, {23'b0, E_RUN});
    @(posedge clk);
    #4;
    chk("mdrst_cnt2", {16'b0, stall_cycles}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline.
- Drives the Load input of every stage register, plus a flush strobe that makes the register capture a bubble (all-zero) on the next edge.
- Resolves load-use hazards, stalls for the multi-cycle MUL/DIV unit, and squashes wrong-path instructions on a taken branch resolved in MEM.
- Keeps a saturating stall-cycle counter.

Parameters:
REG_ADDR_W, 5, register-index width
MD_LATENCY, 4, MUL/DIV cycles from EX entry to result valid (≥1)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
id_rs1  in  REG_ADDR_W  source 1 of instruction in ID
id_rs2  in  REG_ADDR_W  source 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  destination of instruction in EX
ex_reg_write  in  1  EX instruction writes rd
ex_mem_read  in  1  EX instruction is a load
ex_md_op  in  1  EX instruction is MUL/DIV
mem_branch_taken  in  1  taken branch/jump resolved in MEM
pc_load  out  1  PC register Load
if_id_load  out  1  IF/ID Load
id_ex_load  out  1  ID/EX Load
ex_mem_load  out  1  EX/MEM Load
if_id_flush  out  1  IF/ID captures bubble
id_ex_flush  out  1  ID/EX captures bubble
ex_mem_flush  out  1  EX/MEM captures bubble
md_busy  out  1  stall caused by MUL/DIV
md_kill  out  1  abort in-flight MUL/DIV (one-cycle pulse)
stall_cycles  out  CNT_W  count of cycles with pc_load=0

Behaviour:
- State: {RUN, MD_WAIT}, plus down-counter md_cnt (width clog2(MD_LATENCY)+1).
- Outputs are combinational from state and inputs. A flush has effect only with the matching load=1.
- While rst=0:
  - All loads and flushes are 0; md_busy=0, md_kill=0.
  - stall_cycles=0, state=RUN, md_cnt=0.
- Default (no event): all loads=1, all flushes=0.
- Load-use hit:
  - Condition: ex_mem_read & ex_reg_write & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: pc_load=0, if_id_load=0, id_ex_flush=1; ex_mem_load stays 1.
  - Exactly one bubble, since the load advances to MEM.
- RUN priority, highest first: mem_branch_taken, then ex_md_op, then load-use, then default.
- RUN, mem_branch_taken=1:
  - All loads=1; if_id_flush=id_ex_flush=ex_mem_flush=1.
  - Stay in RUN; ex_md_op is ignored.
- RUN, ex_md_op=1, MD_LATENCY=1: treated as default, no stall.
- RUN, ex_md_op=1, MD_LATENCY>1:
  - pc_load=if_id_load=id_ex_load=0, ex_mem_flush=1, md_busy=1.
  - Next state MD_WAIT, md_cnt←MD_LATENCY-2.
- MD_WAIT, mem_branch_taken=1:
  - Same flush outputs as RUN; additionally md_kill=1, md_busy=0.
  - Next state RUN. The MUL/DIV op is younger than the branch, so it is squashed.
- MD_WAIT, md_cnt≠0: same stall outputs as entry; md_cnt decrements.
- MD_WAIT, md_cnt=0: default outputs (result passes to MEM); next state RUN.
- Total MUL/DIV stall = MD_LATENCY-1 cycles.
- Back-to-back: after release, a new ex_md_op in the following cycle re-enters MD_WAIT normally.
- Load-use is not evaluated in MD_WAIT: the ID instruction is held and is re-checked after release.
- stall_cycles increments on every cycle with pc_load=0 and saturates at all-ones. Flush-only cycles do not count.
- Reset asserted mid-MD_WAIT: immediate return to RUN with md_cnt=0. No md_kill is generated, because the MUL/DIV unit is reset by the same rst.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, MD_WAIT), REG_ADDR_W default, bubble encoding constant.
- Sub-module load_use_detect: combinational comparator producing the hit signal.
- Top: FSM, md_cnt, output muxing, stall counter.

Test Plan:
- Reset held 3 cycles → all outputs 0, stall_cycles=0. After release with idle inputs → all loads=1, flushes=0.
- ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, one cycle → exactly one cycle of pc_load=0, if_id_load=0, id_ex_flush=1; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- ex_md_op=1 (MD_LATENCY=4) → 3 stall cycles with md_busy=1 and ex_mem_flush=1; 4th cycle all loads=1; stall_cycles=3.
- Branch in MD_WAIT: ex_md_op=1, then mem_branch_taken=1 on the 2nd stall cycle → that cycle shows md_kill=1 and all three flushes=1; the next cycle is RUN default.
- Same cycle: mem_branch_taken=1 with ex_md_op=1 and a load-use hit → only the branch flush occurs; no stall, state stays RUN.
- Force 65 540 stall cycles (CNT_W=16) → stall_cycles holds at 65535. rst pulse mid-MD_WAIT → RUN, counter 0, md_kill stays 0.
